imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a loader/debug port onto one single-port synchronous
// instruction memory, one transaction in flight, loader priority with fetch anti-starvation.
module imem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [31:0]   f_req_addr,
  output logic          f_rsp_valid,
  input  logic          f_rsp_ready,
  output logic [31:0]   f_rsp_data,
  output logic          f_rsp_err,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [31:0]   l_req_addr,
  input  logic [31:0]   l_req_wdata,
  output logic          l_rsp_valid,
  input  logic          l_rsp_ready,
  output logic [31:0]   l_rsp_data,
  output logic          l_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RSP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic        owner_l;
  logic        op_wr;
  logic [3:0]  starve_cnt;
  logic [31:0] f_data_q, l_data_q;
  logic        f_err_q, l_err_q;

  logic        grant_l, grant_f, accept, illegal, rsp_done;
  logic [31:0] sel_addr;

  // Grant is recomputed every IDLE cycle; reset suppresses both readies.
  always_comb begin
    grant_l = 1'b0;
    grant_f = 1'b0;
    if (!rst && state == IDLE) begin
      if (l_req_valid && !(f_req_valid && starve_cnt == LIMIT))
        grant_l = 1'b1;
      else if (f_req_valid)
        grant_f = 1'b1;
    end
  end

  always_comb begin
    accept   = grant_l | grant_f;
    sel_addr = grant_l ? l_req_addr : f_req_addr;
    illegal  = (|sel_addr[1:0]) | (|sel_addr[31:AW+2]);
    rsp_done = owner_l ? l_rsp_ready : f_rsp_ready;
  end

  assign f_req_ready = grant_f;
  assign l_req_ready = grant_l;

  assign mem_en    = accept && !illegal;
  assign mem_we    = accept && !illegal && grant_l && l_req_we;
  assign mem_addr  = sel_addr[AW+1:2];
  assign mem_wdata = l_req_wdata;

  assign f_rsp_valid = (state == RSP) && !owner_l;
  assign l_rsp_valid = (state == RSP) && owner_l;
  assign f_rsp_data  = f_data_q;
  assign f_rsp_err   = f_err_q;
  assign l_rsp_data  = l_data_q;
  assign l_rsp_err   = l_err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? RSP : ACCESS;
      ACCESS:  state_nxt = RSP;
      RSP:     if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_l    <= 1'b0;
      op_wr      <= 1'b0;
      starve_cnt <= '0;
      f_data_q   <= '0;
      f_err_q    <= 1'b0;
      l_data_q   <= '0;
      l_err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_l <= grant_l;
        op_wr   <= grant_l && l_req_we;
        if (grant_f)
          starve_cnt <= '0;
        else if (f_req_valid && starve_cnt < LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
        // Illegal requests skip ACCESS, so their error response is loaded here.
        if (illegal) begin
          if (grant_l) begin
            l_data_q <= '0;
            l_err_q  <= 1'b1;
          end else begin
            f_data_q <= '0;
            f_err_q  <= 1'b1;
          end
        end
      end
      if (state == ACCESS) begin
        if (owner_l) begin
          l_data_q <= op_wr ? '0 : mem_rdata;
          l_err_q  <= 1'b0;
        end else begin
          f_data_q <= mem_rdata;
          f_err_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1024-word synchronous memory.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_rsp_data;
  logic        l_req_valid, l_req_ready, l_req_we;
  logic [31:0] l_req_addr, l_req_wdata;
  logic        l_rsp_valid, l_rsp_ready, l_rsp_err;
  logic [31:0] l_rsp_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [31:0] pre_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.AW(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data),
    .l_rsp_err(l_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_a] <= pre_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One complete transaction on either port with rsp_ready held high.
  task automatic txn(input string tag, input bit ld, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                     input int exp_lat);
    bit got;
    int lat;
    @(negedge clk);
    if (ld) begin
      l_req_valid = 1'b1; l_req_we = we; l_req_addr = a; l_req_wdata = wd;
    end else begin
      f_req_valid = 1'b1; f_req_addr = a;
    end
    f_rsp_ready = 1'b1; l_rsp_ready = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ld ? l_req_ready : f_req_ready) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    check({tag, "_accept"}, 32'(got), 32'd1);
    check({tag, "_mem_en"}, 32'(mem_en), 32'(!exp_e));
    if (!exp_e) begin
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a[11:2]));
      check({tag, "_mem_we"}, 32'(mem_we), 32'(ld && we));
    end
    @(posedge clk); #1;
    f_req_valid = 1'b0; l_req_valid = 1'b0; l_req_we = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (ld ? l_rsp_valid : f_rsp_valid) begin got = 1'b1; break; end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, ld ? l_rsp_data : f_rsp_data, exp_d);
    check({tag, "_err"}, 32'(ld ? l_rsp_err : f_rsp_err), 32'(exp_e));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rsp_done"}, 32'(f_rsp_valid | l_rsp_valid), 32'd0);
  endtask

  // Both ports request continuously; records who wins each grant (1 = loader).
  task automatic grab(input int n, output logic [15:0] seq, output int cnt, output int both);
    @(negedge clk);
    f_req_valid = 1'b1; f_req_addr = 32'h0;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h4;
    f_rsp_ready = 1'b1; l_rsp_ready = 1'b1;
    cnt = 0; both = 0; seq = '0;
    for (int k = 0; k < 200 && cnt < n; k++) begin
      #1;
      if (f_req_ready && l_req_ready) both++;
      if (l_req_ready) begin seq[cnt] = 1'b1; cnt++; end
      else if (f_req_ready) begin seq[cnt] = 1'b0; cnt++; end
      if (cnt < n) @(negedge clk);
    end
    @(posedge clk); #1;
    f_req_valid = 1'b0; l_req_valid = 1'b0;
  endtask

  logic [15:0] seq;
  int cnt, both, bad;

  initial begin
    rst = 1'b1;
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b1;
    l_req_valid = 1'b0; l_req_we = 1'b0; l_req_addr = '0; l_req_wdata = '0; l_rsp_ready = 1'b1;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    preload(10'd0, 32'h11111111);
    preload(10'd1, 32'h00432283);
    preload(10'd1023, 32'hCAFEF00D);

    // Reset state, and readies forced low while rst is high.
    @(negedge clk);
    f_req_valid = 1'b1; l_req_valid = 1'b1;
    #1;
    check("rst_f_ready", 32'(f_req_ready), 32'd0);
    check("rst_l_ready", 32'(l_req_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rsp_valid", 32'({f_rsp_valid, l_rsp_valid}), 32'd0);
    check("rst_rsp_data", f_rsp_data | l_rsp_data, 32'd0);
    check("rst_rsp_err", 32'({f_rsp_err, l_rsp_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0; f_req_valid = 1'b0; l_req_valid = 1'b0;

    txn("fetch_rd4", 1'b0, 1'b0, 32'h4, '0, 32'h00432283, 1'b0, 2);
    txn("ld_wr8", 1'b1, 1'b1, 32'h8, 32'h406283B3, 32'h0, 1'b0, 2);
    txn("fetch_rd8", 1'b0, 1'b0, 32'h8, '0, 32'h406283B3, 1'b0, 2);

    grab(10, seq, cnt, both);
    check("starve_cnt_grants", 32'(cnt), 32'd10);
    check("starve_order", 32'(seq[9:0]), 32'h1EF);
    check("starve_both_ready", 32'(both), 32'd0);
    repeat (4) @(negedge clk);

    txn("fetch_misalign", 1'b0, 1'b0, 32'h6, '0, 32'h0, 1'b1, 1);
    txn("fetch_range", 1'b0, 1'b0, 32'h1000, '0, 32'h0, 1'b1, 1);
    txn("fetch_top", 1'b0, 1'b0, 32'hFFC, '0, 32'hCAFEF00D, 1'b0, 2);
    txn("ld_wr_misalign", 1'b1, 1'b1, 32'h2, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    txn("fetch_rd0", 1'b0, 1'b0, 32'h0, '0, 32'h11111111, 1'b0, 2);
    txn("ld_rd4", 1'b1, 1'b0, 32'h4, '0, 32'h00432283, 1'b0, 2);

    // Response backpressure: held response stable, no new grants.
    @(negedge clk);
    f_req_valid = 1'b1; f_req_addr = 32'h4; f_rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 20 && !f_req_ready; k++) begin @(negedge clk); #1; end
    check("bp_accept", 32'(f_req_ready), 32'd1);
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h8;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!f_rsp_valid || f_rsp_data !== 32'h00432283 || f_rsp_err || f_req_ready ||
          l_req_ready || l_rsp_valid) bad++;
      if (k < 4) @(negedge clk);
    end
    check("bp_stable_cycles", 32'(bad), 32'd0);
    f_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_done", 32'(f_rsp_valid), 32'd0);
    check("bp_idle_grant", 32'(l_req_ready), 32'd1);
    l_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ACCESS with the starvation counter at its limit.
    grab(4, seq, cnt, both);
    check("pre_rst_grants", 32'(seq[3:0]), 32'hF);
    rst = 1'b1; f_req_valid = 1'b1; l_req_valid = 1'b1;
    #1;
    check("rst_access_ready", 32'({f_req_ready, l_req_ready}), 32'd0);
    check("rst_access_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (f_rsp_valid || l_rsp_valid) bad++;
      rst = 1'b0; f_req_valid = 1'b0; l_req_valid = 1'b0;
    end
    check("rst_no_rsp", 32'(bad), 32'd0);
    grab(1, seq, cnt, both);
    check("rst_starve_cleared", 32'(seq[0]), 32'd1);
    repeat (4) @(negedge clk);
    txn("post_rst_rd4", 1'b0, 1'b0, 32'h4, '0, 32'h00432283, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
